// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared constants, state/reason enums and filter helpers
// for the RX store-and-forward frame filter.
package eth_rx_pkg;

  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned IG_BIT = 40;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DISCARD
  } wr_state_t;

  typedef enum logic [1:0] {
    DROP_NONE,
    DROP_OVF,
    DROP_ERR,
    DROP_FILT
  } drop_reason_t;

  function automatic logic addr_pass(
    input logic [47:0] dst,
    input logic [47:0] lmac,
    input logic        promisc,
    input logic        mcast_en
  );
    return promisc
        || (dst == lmac)
        || (dst == MAC_BCAST)
        || (mcast_en && dst[IG_BIT]);
  endfunction

  // Outcome priority: overflow beats error beats address filter.
  function automatic drop_reason_t eof_reason(
    input logic ovf,
    input logic bad,
    input logic seen,
    input logic pass
  );
    if (ovf) return DROP_OVF;
    if (bad || !seen) return DROP_ERR;
    if (!pass) return DROP_FILT;
    return DROP_NONE;
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// eth_sdp_ram: simple dual-port RAM, one write port and one
// synchronous read port, written to map onto block RAM.
module eth_sdp_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter: buffers each received frame, then commits or
// rolls it back at tlast; only accepted frames reach the output AXIS.
module eth_rx_frame_filter
  import eth_rx_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  input  logic             meta_valid,
  input  logic [47:0]      meta_dst_mac,
  input  logic [15:0]      meta_ethertype,
  input  logic [47:0]      cfg_local_mac,
  input  logic             cfg_promisc,
  input  logic             cfg_mcast_en,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] cnt_rx_ok,
  output logic [CNT_W-1:0] cnt_drop_filt,
  output logic [CNT_W-1:0] cnt_drop_err,
  output logic [CNT_W-1:0] cnt_drop_ovf
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + CNT_ONE;
  endfunction

  wr_state_t       state_q;
  logic [ADDR_W:0] wr_ptr_q;
  logic [ADDR_W:0] wr_commit_q;
  logic [ADDR_W:0] rd_ptr_q;
  logic            ovf_q;
  logic            meta_seen_q;
  logic [47:0]     dst_q;
  logic            s_rdy_q;

  logic [CNT_W-1:0] ok_q;
  logic [CNT_W-1:0] filt_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] ovfc_q;

  logic            ram_vld_q;
  logic            m_valid_q;
  logic [7:0]      m_data_q;
  logic            m_last_q;

  logic            beat;
  logic            eof;
  logic            full;
  logic            writing;
  logic            we;
  logic            ovf_now;
  logic            seen_now;
  logic [47:0]     dst_now;
  logic            pass_now;
  drop_reason_t    reason;

  logic            avail;
  logic            load_out;
  logic            re;
  logic [8:0]      ram_rdata;

  logic            unused_meta;
  assign unused_meta = ^meta_ethertype;

  assign beat    = s_axis_tvalid && s_rdy_q;
  assign eof     = beat && s_axis_tlast;
  assign full    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0])
                && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign writing = beat && (state_q != DISCARD);
  assign we      = writing && !full;
  assign ovf_now = ovf_q || (writing && full);

  // A meta pulse on the tlast beat still belongs to this frame.
  assign seen_now = meta_seen_q || meta_valid;
  assign dst_now  = meta_valid ? meta_dst_mac : dst_q;
  assign pass_now = addr_pass(dst_now, cfg_local_mac,
                              cfg_promisc, cfg_mcast_en);
  assign reason   = eof_reason(ovf_now, s_axis_tuser,
                               seen_now, pass_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      ovf_q       <= 1'b0;
      meta_seen_q <= 1'b0;
      dst_q       <= '0;
      s_rdy_q     <= 1'b0;
    end else begin
      s_rdy_q <= 1'b1;
      if (meta_valid) begin
        dst_q       <= meta_dst_mac;
        meta_seen_q <= 1'b1;
      end
      if (we) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (eof) begin
        state_q     <= IDLE;
        ovf_q       <= 1'b0;
        meta_seen_q <= 1'b0;
        dst_q       <= '0;
        if (reason == DROP_NONE)
          wr_commit_q <= wr_ptr_q + PTR_ONE;
        else
          wr_ptr_q <= wr_commit_q;
      end else if (writing && full) begin
        state_q <= DISCARD;
        ovf_q   <= 1'b1;
      end else if (beat && state_q == IDLE) begin
        state_q <= WRITE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q   <= '0;
      filt_q <= '0;
      err_q  <= '0;
      ovfc_q <= '0;
    end else if (eof) begin
      unique case (reason)
        DROP_NONE: ok_q   <= sat_inc(ok_q);
        DROP_OVF:  ovfc_q <= sat_inc(ovfc_q);
        DROP_ERR:  err_q  <= sat_inc(err_q);
        DROP_FILT: filt_q <= sat_inc(filt_q);
      endcase
    end
  end

  eth_sdp_ram #(
    .DEPTH(DEPTH),
    .WIDTH(9),
    .AW   (ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(wr_ptr_q[ADDR_W-1:0]),
    .wdata_i({s_axis_tlast, s_axis_tdata}),
    .re_i   (re),
    .raddr_i(rd_ptr_q[ADDR_W-1:0]),
    .rdata_o(ram_rdata)
  );

  // Two-stage read: RAM output stage then output register; the RAM
  // is only re-read when its current word moves on, so it holds.
  assign avail    = rd_ptr_q != wr_commit_q;
  assign load_out = ram_vld_q && (!m_valid_q || m_axis_tready);
  assign re       = avail && (!ram_vld_q || load_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      ram_vld_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      if (re) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (re) ram_vld_q <= 1'b1;
      else if (load_out) ram_vld_q <= 1'b0;
      if (load_out) begin
        m_valid_q <= 1'b1;
        m_data_q  <= ram_rdata[7:0];
        m_last_q  <= ram_rdata[8];
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign s_axis_tready = s_rdy_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign cnt_rx_ok     = ok_q;
  assign cnt_drop_filt = filt_q;
  assign cnt_drop_err  = err_q;
  assign cnt_drop_ovf  = ovfc_q;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// tb_eth_rx_frame_filter: directed and randomized frames checked against
// a frame-level reference model (verdict + expected byte queue).
module tb_eth_rx_frame_filter;

  localparam int DEPTH = 64;
  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        meta_valid;
  logic [47:0] meta_dst_mac;
  logic [15:0] meta_ethertype;
  logic [47:0] cfg_local_mac;
  logic        cfg_promisc;
  logic        cfg_mcast_en;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] cnt_rx_ok;
  logic [31:0] cnt_drop_filt;
  logic [31:0] cnt_drop_err;
  logic [31:0] cnt_drop_ovf;

  eth_rx_frame_filter #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .meta_valid    (meta_valid),
    .meta_dst_mac  (meta_dst_mac),
    .meta_ethertype(meta_ethertype),
    .cfg_local_mac (cfg_local_mac),
    .cfg_promisc   (cfg_promisc),
    .cfg_mcast_en  (cfg_mcast_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .cnt_rx_ok     (cnt_rx_ok),
    .cnt_drop_filt (cnt_drop_filt),
    .cnt_drop_err  (cnt_drop_err),
    .cnt_drop_ovf  (cnt_drop_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int e_ok, e_filt, e_err, e_ovf;
  logic [8:0] exp_q[$];
  bit rand_rdy;
  bit fixed_rdy;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_ok"}, 64'(cnt_rx_ok), 64'(e_ok));
    chk({tag, "_filt"}, 64'(cnt_drop_filt), 64'(e_filt));
    chk({tag, "_err"}, 64'(cnt_drop_err), 64'(e_err));
    chk({tag, "_ovf"}, 64'(cnt_drop_ovf), 64'(e_ovf));
  endtask

  // 0 accept, 1 overflow, 2 error/no-meta, 3 address filter
  function automatic int verdict(bit ovf, bit user, bit seen,
                                 logic [47:0] dst);
    bit hit;
    if (ovf) return 1;
    if (user || !seen) return 2;
    hit = cfg_promisc || dst == cfg_local_mac
       || dst == 48'hFFFF_FFFF_FFFF || (cfg_mcast_en && dst[40]);
    return hit ? 0 : 3;
  endfunction

  // mode: 0 no meta, 1 one pulse, 2 decoy pulse first then real one
  task automatic send_frame(input int len, input logic [47:0] dst,
                            input int mode, input bit user,
                            input bit ovf, input bit gaps);
    logic [7:0] bytes[$];
    int mpos;
    int v;
    mpos = int'($urandom_range(len - 1));
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(7) == 0) begin
        s_axis_tvalid = 1'b0;
        meta_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 8'($urandom);
      s_axis_tlast = (i == len - 1);
      s_axis_tuser = (i == len - 1) ? user : 1'($urandom);
      meta_valid = 1'b0;
      if (mode == 2 && i == 0 && mpos > 0) begin
        meta_valid = 1'b1;
        meta_dst_mac = {16'($urandom), $urandom};
      end
      if (mode != 0 && i == mpos) begin
        meta_valid = 1'b1;
        meta_dst_mac = dst;
      end
      bytes.push_back(s_axis_tdata);
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    meta_valid = 1'b0;
    v = verdict(ovf, user, mode != 0, dst);
    case (v)
      0: begin
        e_ok++;
        for (int i = 0; i < len; i++)
          exp_q.push_back({1'(i == len - 1), bytes[i]});
      end
      1: e_ovf++;
      2: e_err++;
      default: e_filt++;
    endcase
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_idle_tvalid"}, 64'(m_axis_tvalid), 64'd0);
  endtask

  task automatic reset_checks(input string tag);
    exp_q.delete();
    e_ok = 0; e_filt = 0; e_err = 0; e_ovf = 0;
    chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
    chk_cnt(tag);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(s_axis_tready), 64'd1);
  endtask

  function automatic logic [47:0] pick_dst();
    case ($urandom_range(3))
      0: return LMAC;
      1: return 48'hFFFF_FFFF_FFFF;
      2: return {16'h0100, $urandom};
      default: return {8'h0A, 8'($urandom), $urandom};
    endcase
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int mode;
    bit user;
    rst_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    meta_valid = 1'b0;
    meta_dst_mac = '0;
    meta_ethertype = 16'h0800;
    cfg_local_mac = LMAC;
    cfg_promisc = 1'b0;
    cfg_mcast_en = 1'b0;
    m_axis_tready = 1'b0;
    rand_rdy = 1'b0;
    fixed_rdy = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && m_axis_tvalid && m_axis_tready)
          chk("out_beat", 64'({m_axis_tlast, m_axis_tdata}),
              exp_q.size() != 0 ? 64'(exp_q.pop_front()) : 64'hDEAD);
      end
      forever begin
        @(posedge clk); #1;
        m_axis_tready = rand_rdy ? ($urandom_range(3) != 0) : fixed_rdy;
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst0");
    release_reset();
    repeat (2) @(posedge clk);
    #1;

    // unicast hit, 64 bytes = full buffer, first-beat latency
    send_frame(64, LMAC, 1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("lat_cycle1", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", 64'(m_axis_tvalid), 64'd1);
    drain("t1");
    chk_cnt("t1");

    send_frame(30, 48'h02_00_00_00_00_99, 1, 1'b0, 1'b0, 1'b1);
    drain("t2a");
    chk_cnt("t2a");
    cfg_promisc = 1'b1;
    send_frame(30, 48'h02_00_00_00_00_99, 1, 1'b0, 1'b0, 1'b1);
    drain("t2b");
    chk_cnt("t2b");
    cfg_promisc = 1'b0;

    send_frame(60, 48'hFFFF_FFFF_FFFF, 1, 1'b0, 1'b0, 1'b1);
    send_frame(20, 48'h01_00_5E_00_00_01, 1, 1'b0, 1'b0, 1'b1);
    drain("t3a");
    chk_cnt("t3a");
    cfg_mcast_en = 1'b1;
    send_frame(20, 48'h01_00_5E_00_00_01, 2, 1'b0, 1'b0, 1'b1);
    drain("t3b");
    chk_cnt("t3b");
    cfg_mcast_en = 1'b0;

    send_frame(18, LMAC, 1, 1'b0, 1'b0, 1'b0);
    send_frame(18, LMAC, 1, 1'b1, 1'b0, 1'b0);
    send_frame(18, LMAC, 1, 1'b0, 1'b0, 1'b0);
    drain("t4a");
    chk_cnt("t4a");
    send_frame(25, LMAC, 0, 1'b0, 1'b0, 1'b1);
    drain("t4b");
    chk_cnt("t4b");

    // overflow: stalled output, 40 + 40 bytes into a 64-byte buffer
    fixed_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(40, LMAC, 1, 1'b0, 1'b0, 1'b1);
    send_frame(40, LMAC, 1, 1'b0, 1'b1, 1'b1);
    chk_cnt("t5a");
    fixed_rdy = 1'b1;
    drain("t5a");
    send_frame(100, LMAC, 1, 1'b0, 1'b1, 1'b0);
    send_frame(65, LMAC, 1, 1'b0, 1'b1, 1'b0);
    drain("t5b");
    chk_cnt("t5b");

    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(72, 1));
      mode = ($urandom_range(9) == 0) ? 0
           : (($urandom_range(2) == 0) ? 2 : 1);
      user = ($urandom_range(5) == 0);
      cfg_promisc = ($urandom_range(4) == 0);
      cfg_mcast_en = 1'($urandom);
      send_frame(len, pick_dst(), mode, user, len > DEPTH, 1'b1);
      drain("rnd");
      chk_cnt("rnd");
    end
    rand_rdy = 1'b0;
    cfg_promisc = 1'b0;
    cfg_mcast_en = 1'b0;
    fixed_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of an input frame
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 8'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    reset_checks("rst_frame");
    release_reset();

    // reset while a committed frame is held at the output
    fixed_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(20, LMAC, 1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("rst_read");
    fixed_rdy = 1'b1;
    release_reset();
    repeat (2) @(posedge clk);
    #1;
    send_frame(33, LMAC, 1, 1'b0, 1'b0, 1'b1);
    drain("post_rst");
    chk_cnt("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
